// File: rtl/chroni_bitmap_expander_if.sv
// Request and line-buffer write-port bundle for the chroni bitmap expander.
// The fetch FSM drives the request side and the expander drives the write port.
interface chroni_bitmap_expander_if #(
  parameter int ADDR_W = 11,
  parameter int PIX_W  = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [3:0]        wr_bitmap_bits;
  logic [PIX_W-1:0]  wr_bitmap_on;
  logic [PIX_W-1:0]  wr_bitmap_off;
  logic              wr_transparent;
  logic              wr_double;
  logic              busy;
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic [PIX_W-1:0]  buf_wr_data;

  modport master (
    output wr_en, wr_addr, wr_data, wr_bitmap_bits, wr_bitmap_on, wr_bitmap_off,
           wr_transparent, wr_double,
    input  busy, buf_wr_en, buf_wr_addr, buf_wr_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_bitmap_bits, wr_bitmap_on, wr_bitmap_off,
           wr_transparent, wr_double,
    output busy, buf_wr_en, buf_wr_addr, buf_wr_data
  );
endinterface

// File: rtl/chroni_bitmap_expander.sv
// Expands one bitmap byte (or one raw pixel) into per-cycle line buffer writes, MSB first,
// with optional transparency of '0' bits and 2x horizontal doubling.
module chroni_bitmap_expander #(
  parameter int ADDR_W = 11,
  parameter int PIX_W  = 8
) (
  input  logic                     sys_clk,
  input  logic                     reset_n,
  input  logic                     abort,
  chroni_bitmap_expander_if.slave  bus
);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t            state_q, state_d;
  logic [3:0]        rem_q, rem_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  raw_q, raw_d;
  logic [PIX_W-1:0]  on_q, on_d;
  logic [PIX_W-1:0]  off_q, off_d;
  logic              raw_mode_q, raw_mode_d;
  logic              transp_q, transp_d;
  logic              double_q, double_d;
  logic              buf_en_q, buf_en_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [PIX_W-1:0]  buf_data_q, buf_data_d;

  logic              req_raw;
  logic [3:0]        req_nbits;
  logic [4:0]        req_nslots;

  function automatic logic slot_en(input logic raw, input logic bit_v, input logic transp);
    return raw | bit_v | ~transp;
  endfunction

  function automatic logic [PIX_W-1:0] slot_pix(input logic raw, input logic bit_v,
                                                input logic [PIX_W-1:0] raw_pix,
                                                input logic [PIX_W-1:0] on_pix,
                                                input logic [PIX_W-1:0] off_pix);
    if (raw)        return raw_pix;
    else if (bit_v) return on_pix;
    else            return off_pix;
  endfunction

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    shreg_d    = shreg_q;
    phase_d    = phase_q;
    addr_d     = addr_q;
    raw_d      = raw_q;
    on_d       = on_q;
    off_d      = off_q;
    raw_mode_d = raw_mode_q;
    transp_d   = transp_q;
    double_d   = double_q;
    buf_en_d   = 1'b0;
    buf_addr_d = '0;
    buf_data_d = '0;

    req_raw    = (bus.wr_bitmap_bits == 4'd0);
    req_nbits  = req_raw ? 4'd1 : ((bus.wr_bitmap_bits > 4'd8) ? 4'd8 : bus.wr_bitmap_bits);
    req_nslots = bus.wr_double ? {req_nbits, 1'b0} : {1'b0, req_nbits};

    unique case (state_q)
      IDLE: begin
        if (bus.wr_en && !abort) begin
          // The first slot is emitted straight from the request so it shows up one cycle later.
          state_d    = EXPAND;
          rem_d      = 4'(req_nslots - 5'd1);
          raw_mode_d = req_raw;
          raw_d      = PIX_W'(bus.wr_data);
          on_d       = bus.wr_bitmap_on;
          off_d      = bus.wr_bitmap_off;
          transp_d   = bus.wr_transparent;
          double_d   = bus.wr_double;
          shreg_d    = bus.wr_double ? bus.wr_data : (bus.wr_data << 1);
          phase_d    = bus.wr_double;
          addr_d     = bus.wr_addr + ADDR_W'(1);
          buf_en_d   = slot_en(req_raw, bus.wr_data[7], bus.wr_transparent);
          buf_addr_d = bus.wr_addr;
          buf_data_d = slot_pix(req_raw, bus.wr_data[7], PIX_W'(bus.wr_data),
                                bus.wr_bitmap_on, bus.wr_bitmap_off);
        end
      end
      EXPAND: begin
        if (abort || rem_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          buf_en_d   = slot_en(raw_mode_q, shreg_q[7], transp_q);
          buf_addr_d = addr_q;
          buf_data_d = slot_pix(raw_mode_q, shreg_q[7], raw_q, on_q, off_q);
          addr_d     = addr_q + ADDR_W'(1);
          rem_d      = rem_q - 4'd1;
          // In 2x mode the current bit is held for a second slot before shifting.
          if (!double_q || phase_q) shreg_d = shreg_q << 1;
          phase_d    = double_q & ~phase_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      shreg_q    <= '0;
      phase_q    <= 1'b0;
      addr_q     <= '0;
      raw_q      <= '0;
      on_q       <= '0;
      off_q      <= '0;
      raw_mode_q <= 1'b0;
      transp_q   <= 1'b0;
      double_q   <= 1'b0;
      buf_en_q   <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      shreg_q    <= shreg_d;
      phase_q    <= phase_d;
      addr_q     <= addr_d;
      raw_q      <= raw_d;
      on_q       <= on_d;
      off_q      <= off_d;
      raw_mode_q <= raw_mode_d;
      transp_q   <= transp_d;
      double_q   <= double_d;
      buf_en_q   <= buf_en_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
    end
  end

  assign bus.busy        = (state_q == EXPAND);
  assign bus.buf_wr_en   = buf_en_q;
  assign bus.buf_wr_addr = buf_addr_q;
  assign bus.buf_wr_data = buf_data_q;

endmodule

// File: tb/tb_chroni_bitmap_expander.sv
// Scoreboard bench for chroni_bitmap_expander: requests push their expected writes into a
// queue computed from the pixel rules; a negedge monitor pops and compares every write.
module tb_chroni_bitmap_expander;
  localparam int ADDR_W = 11;
  localparam int PIX_W  = 8;

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  logic abort   = 1'b0;
  int   cyc     = 0;
  int   checks  = 0;
  int   failures = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
    int                cyc;
  } exp_t;

  exp_t exp_q[$];

  chroni_bitmap_expander_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

  chroni_bitmap_expander #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .abort   (abort),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Reference: N bits (raw counts as one), each repeated rep times; a slot writes unless
  // it is a transparent '0' bit. acc is the cycle count at which slot 0 is observed.
  function automatic int model(input logic [ADDR_W-1:0] addr, input logic [7:0] data,
                               input logic [3:0] bits, input logic [PIX_W-1:0] on_c,
                               input logic [PIX_W-1:0] off_c, input logic tr, input logic db,
                               input int acc);
    int   nb;
    int   rep;
    logic raw;
    exp_t e;
    raw = (bits == 4'd0);
    nb  = raw ? 1 : ((bits > 4'd8) ? 8 : int'(bits));
    rep = db ? 2 : 1;
    for (int i = 0; i < nb; i++) begin
      for (int r = 0; r < rep; r++) begin
        if (raw || data[7-i] || !tr) begin
          e.addr = ADDR_W'(int'(addr) + i*rep + r);
          e.data = raw ? PIX_W'(data) : (data[7-i] ? on_c : off_c);
          e.cyc  = acc + i*rep + r;
          exp_q.push_back(e);
        end
      end
    end
    return nb * rep;
  endfunction

  always @(negedge sys_clk) begin : monitor
    exp_t e;
    if (reset_n && bus.buf_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%0h expected no write",
                 bus.buf_wr_addr, bus.buf_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.buf_wr_addr), 32'(e.addr));
        check("wr_data", 32'(bus.buf_wr_data), 32'(e.data));
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drive_req(input logic [ADDR_W-1:0] addr, input logic [7:0] data,
                           input logic [3:0] bits, input logic [PIX_W-1:0] on_c,
                           input logic [PIX_W-1:0] off_c, input logic tr, input logic db);
    bus.wr_en          = 1'b1;
    bus.wr_addr        = addr;
    bus.wr_data        = data;
    bus.wr_bitmap_bits = bits;
    bus.wr_bitmap_on   = on_c;
    bus.wr_bitmap_off  = off_c;
    bus.wr_transparent = tr;
    bus.wr_double      = db;
  endtask

  // Called on a negedge with busy low; returns on the first negedge with busy low again.
  task automatic issue(input logic [ADDR_W-1:0] addr, input logic [7:0] data,
                       input logic [3:0] bits, input logic [PIX_W-1:0] on_c,
                       input logic [PIX_W-1:0] off_c, input logic tr, input logic db,
                       input logic junk);
    int n;
    int cnt;
    drive_req(addr, data, bits, on_c, off_c, tr, db);
    n = model(addr, data, bits, on_c, off_c, tr, db, cyc + 1);
    @(negedge sys_clk);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      cnt++;
      if (junk) begin
        bus.wr_en          = 1'($urandom);
        bus.wr_addr        = ADDR_W'($urandom);
        bus.wr_data        = 8'($urandom);
        bus.wr_bitmap_bits = 4'($urandom);
        bus.wr_bitmap_on   = PIX_W'($urandom);
        bus.wr_transparent = 1'($urandom);
        bus.wr_double      = 1'($urandom);
      end else begin
        bus.wr_en = 1'b0;
      end
      @(negedge sys_clk);
    end
    bus.wr_en = 1'b0;
    check("busy_cycles", cnt, n);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_en"},   32'(bus.buf_wr_en), 0);
    check({tag, "_addr"}, 32'(bus.buf_wr_addr), 0);
    check({tag, "_data"}, 32'(bus.buf_wr_data), 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    drive_req('0, '0, '0, '0, '0, 1'b0, 1'b0);
    bus.wr_en = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge sys_clk);

    issue(11'd16,   8'hA5, 4'd8,  8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
    issue(11'd5,    8'h3C, 4'd0,  8'h77, 8'h66, 1'b0, 1'b0, 1'b0);
    issue(11'd40,   8'h5A, 4'd12, 8'hE1, 8'h1E, 1'b0, 1'b0, 1'b0);
    issue(11'd0,    8'h81, 4'd8,  8'h33, 8'h44, 1'b1, 1'b0, 1'b0);
    issue(11'd100,  8'hC0, 4'd2,  8'h22, 8'h55, 1'b0, 1'b1, 1'b0);
    issue(11'd2046, 8'hF0, 4'd4,  8'h9A, 8'h10, 1'b0, 1'b0, 1'b1);
    issue(11'd700,  8'h6B, 4'd0,  8'h01, 8'h02, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      issue(ADDR_W'($urandom), 8'($urandom), 4'($urandom), PIX_W'($urandom),
            PIX_W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Abort after the third write.
    n = model(11'd300, 8'hFF, 4'd8, 8'h44, 8'h00, 1'b0, 1'b0, cyc + 1);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    drive_req(11'd300, 8'hFF, 4'd8, 8'h44, 8'h00, 1'b0, 1'b0);
    @(negedge sys_clk);
    bus.wr_en = 1'b0;
    repeat (2) @(negedge sys_clk);
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    check_idle_outputs("abort");

    // Abort and request together in idle: request dropped.
    drive_req(11'd12, 8'hFF, 4'd8, 8'h11, 8'h22, 1'b0, 1'b0);
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    bus.wr_en = 1'b0;
    check("abort_wins_busy", 32'(bus.busy), 0);
    @(negedge sys_clk);
    check("abort_wins_busy2", 32'(bus.busy), 0);

    // Asynchronous reset after the third write.
    n = model(11'd500, 8'hAA, 4'd8, 8'h5C, 8'hC5, 1'b0, 1'b0, cyc + 1);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    drive_req(11'd500, 8'hAA, 4'd8, 8'h5C, 8'hC5, 1'b0, 1'b0);
    @(negedge sys_clk);
    bus.wr_en = 1'b0;
    repeat (2) @(negedge sys_clk);
    #1 reset_n = 1'b0;
    #1 check_idle_outputs("rst_mid");
    @(negedge sys_clk);
    reset_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("post_rst_busy", 32'(bus.busy), 0);

    issue(11'd2047, 8'h96, 4'd3, 8'hAB, 8'hCD, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge sys_clk);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
